alu_share_arbiter: RTL

//  Shares one combinational 64-bit ALU between two requesters. Picks a requester round-robin,

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ctl_decode.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing arbiter: ALU control codes, R-format opcodes,
// ALUOp encodings and the arbiter FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [10:0] OPC_AND   = 11'b10001010000;
  localparam logic [10:0] OPC_ORR   = 11'b10101010000;
  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_PASSB = 11'b11111000010;
  localparam logic [10:0] OPC_NOR   = 11'b11101010000;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_BAD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/opcode to 4-bit ALU control decoder with illegal-encoding flag.
// Shared with the control-unit tests.
module alu_ctl_decode
  import alu_pkg::*;
#(
  parameter int OPC_W = 11
) (
  input  logic [1:0]       aluop,
  input  logic [OPC_W-1:0] opcode,
  output logic [3:0]       ctl,
  output logic             illegal
);

  // Map ALUOp (and the R-format opcode when ALUOp selects it) onto an ALU control code.
  always_comb begin
    ctl     = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM: begin
        ctl     = ALU_ADD;
        illegal = 1'b0;
      end
      ALUOP_BRANCH: begin
        ctl     = ALU_PASSB;
        illegal = 1'b0;
      end
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_AND:   ctl = ALU_AND;
          OPC_ORR:   ctl = ALU_OR;
          OPC_ADD:   ctl = ALU_ADD;
          OPC_SUB:   ctl = ALU_SUB;
          OPC_PASSB: ctl = ALU_PASSB;
          OPC_NOR:   ctl = ALU_NOR;
          default: begin
            ctl     = ALU_AND;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        ctl     = ALU_AND;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a registered
// valid/ready response carrying the owner id, result, zero flag and illegal-op error.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int OPC_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_aluop,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_aluop,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  arb_state_t        state_r;
  logic              last_grant_r;
  logic              gnt_s;
  logic              any_s;
  logic              idle_s;
  logic [1:0]        sel_aluop_s;
  logic [OPC_W-1:0]  sel_opcode_s;
  logic [DATA_W-1:0] sel_a_s;
  logic [DATA_W-1:0] sel_b_s;
  logic [3:0]        dec_ctl_s;
  logic              dec_illegal_s;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    gnt_s = 1'b0;
    any_s = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_s = ~last_grant_r;
      any_s = 1'b1;
    end else if (req0_valid) begin
      gnt_s = 1'b0;
      any_s = 1'b1;
    end else if (req1_valid) begin
      gnt_s = 1'b1;
      any_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
      any_s = 1'b0;
    end
  end

  // Operand and opcode steering from the granted requester.
  always_comb begin
    sel_aluop_s  = req0_aluop;
    sel_opcode_s = req0_opcode;
    sel_a_s      = req0_a;
    sel_b_s      = req0_b;
    if (gnt_s) begin
      sel_aluop_s  = req1_aluop;
      sel_opcode_s = req1_opcode;
      sel_a_s      = req1_a;
      sel_b_s      = req1_b;
    end else begin
      sel_aluop_s  = req0_aluop;
      sel_opcode_s = req0_opcode;
      sel_a_s      = req0_a;
      sel_b_s      = req0_b;
    end
  end

  assign idle_s     = (state_r == ST_IDLE);
  assign req0_ready = idle_s && any_s && !gnt_s;
  assign req1_ready = idle_s && any_s && gnt_s;

  alu_ctl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .aluop   (sel_aluop_s),
    .opcode  (sel_opcode_s),
    .ctl     (dec_ctl_s),
    .illegal (dec_illegal_s)
  );

  // Arbiter FSM; ALU drive and response registers only change on the transitions below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_ctl      <= 4'b0000;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            last_grant_r <= gnt_s;
            rsp_id       <= gnt_s;
            if (dec_illegal_s) begin
              // Illegal ops skip the ALU entirely and keep its inputs quiet.
              rsp_result <= '0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              alu_a   <= sel_a_s;
              alu_b   <= sel_b_s;
              alu_ctl <= dec_ctl_s;
              rsp_err <= 1'b0;
              state_r <= ST_EXEC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
          state_r    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
